// File: rtl/aq_axis_pack64.sv
`default_nettype none
// ============================================================================
//  Module   : aq_axis_pack64
//  Purpose  : Packs a 32-bit AXI-Stream into 64-bit beats for a DMA write
//             port, with a 2-entry output FIFO and per-frame beat counting.
//  Revision : 1.0 - initial release
// ============================================================================
module aq_axis_pack64 #(
    parameter int CNT_W     = 16,
    parameter bit SWAP_HALF = 1'b0
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [31:0]      S_AXIS_TDATA,
    input  logic             S_AXIS_TVALID,
    output logic             S_AXIS_TREADY,
    input  logic             S_AXIS_TLAST,
    output logic [63:0]      M_AXIS_TDATA,
    output logic             M_AXIS_TVALID,
    input  logic             M_AXIS_TREADY,
    output logic [7:0]       M_AXIS_TSTRB,
    output logic             M_AXIS_TKEEP,
    output logic             M_AXIS_TLAST,
    output logic [CNT_W-1:0] FRAME_BEATS,
    output logic             FRAME_DONE
);

    localparam logic [0:0] ST_LOW  = 1'b0;   // no word held
    localparam logic [0:0] ST_HIGH = 1'b1;   // one word held in r_hold

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [31:0]      r_hold;
    logic             r_s_ready;

    logic [63:0]      r_fifo_data [0:1];
    logic [7:0]       r_fifo_strb [0:1];
    logic             r_fifo_last [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [1:0]       w_count_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] r_frame_beats;
    logic             r_frame_done;

    logic             w_acc;
    logic             w_pop;
    logic             w_push;
    logic [63:0]      w_push_data;
    logic [7:0]       w_push_strb;
    logic             w_push_last;

    assign w_acc       = S_AXIS_TVALID & r_s_ready;
    assign w_pop       = (r_count != 2'd0) & M_AXIS_TREADY;
    assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);
    assign w_cnt_inc   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // Pack state register
    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= ST_LOW;
        else        r_state <= w_state_nxt;
    end

    // Next state: a lone word moves to HIGH, any word in HIGH returns to LOW
    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) begin
            case (r_state)
                ST_LOW:  if (!S_AXIS_TLAST) w_state_nxt = ST_HIGH;
                ST_HIGH: w_state_nxt = ST_LOW;
                default: w_state_nxt = ST_LOW;
            endcase
        end
    end

    // Beat build: half beat for a LOW-state TLAST word, full beat from HIGH
    always_comb begin
        w_push      = 1'b0;
        w_push_data = 64'd0;
        w_push_strb = 8'd0;
        w_push_last = 1'b0;
        if (w_acc) begin
            case (r_state)
                ST_LOW: begin
                    if (S_AXIS_TLAST) begin
                        w_push      = 1'b1;
                        w_push_last = 1'b1;
                        w_push_data = SWAP_HALF ? {S_AXIS_TDATA, 32'd0} : {32'd0, S_AXIS_TDATA};
                        w_push_strb = SWAP_HALF ? 8'hF0 : 8'h0F;
                    end
                end
                ST_HIGH: begin
                    w_push      = 1'b1;
                    w_push_last = S_AXIS_TLAST;
                    w_push_data = SWAP_HALF ? {r_hold, S_AXIS_TDATA} : {S_AXIS_TDATA, r_hold};
                    w_push_strb = 8'hFF;
                end
                default: ;
            endcase
        end
    end

    // Hold register captures the first word of a pair
    always_ff @(posedge ACLK) begin
        if (ARESET)
            r_hold <= 32'd0;
        else if (w_acc && (r_state == ST_LOW) && !S_AXIS_TLAST)
            r_hold <= S_AXIS_TDATA;
    end

    // Output FIFO; ready is registered from the next occupancy so the input
    // side never sees a combinational path from M_AXIS_TREADY
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= 64'd0;
                r_fifo_strb[i] <= 8'd0;
                r_fifo_last[i] <= 1'b0;
            end
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_s_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_push_data;
                r_fifo_strb[r_wr_ptr] <= w_push_strb;
                r_fifo_last[r_wr_ptr] <= w_push_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count   <= w_count_nxt;
            r_s_ready <= (w_count_nxt != 2'd2);
        end
    end

    // Beat counter and frame completion reporting
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_cnt         <= '0;
            r_frame_beats <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_pop) begin
                if (M_AXIS_TLAST) begin
                    r_frame_beats <= w_cnt_inc;
                    r_cnt         <= '0;
                    r_frame_done  <= 1'b1;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign S_AXIS_TREADY = r_s_ready;
    assign M_AXIS_TVALID = (r_count != 2'd0);
    assign M_AXIS_TDATA  = r_fifo_data[r_rd_ptr];
    assign M_AXIS_TSTRB  = r_fifo_strb[r_rd_ptr];
    assign M_AXIS_TLAST  = r_fifo_last[r_rd_ptr];
    assign M_AXIS_TKEEP  = 1'b1;
    assign FRAME_BEATS   = r_frame_beats;
    assign FRAME_DONE    = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_aq_axis_pack64.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aq_axis_pack64
//  Purpose  : Self-checking bench for aq_axis_pack64 (table + scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aq_axis_pack64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tready, s_tlast;
    logic [63:0] m_tdata;
    logic        m_tvalid, m_tready, m_tkeep, m_tlast;
    logic [7:0]  m_tstrb;
    logic [15:0] frame_beats;
    logic        frame_done;

    logic [31:0] sw_s_tdata;
    logic        sw_s_tvalid, sw_s_tready, sw_s_tlast;
    logic [63:0] sw_m_tdata;
    logic        sw_m_tvalid, sw_m_tkeep, sw_m_tlast;
    logic [7:0]  sw_m_tstrb;
    logic [15:0] sw_frame_beats;
    logic        sw_frame_done;

    always #5 clk = ~clk;

    aq_axis_pack64 #(.CNT_W(16), .SWAP_HALF(1'b0)) dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
        .S_AXIS_TLAST(s_tlast),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
        .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TKEEP(m_tkeep), .M_AXIS_TLAST(m_tlast),
        .FRAME_BEATS(frame_beats), .FRAME_DONE(frame_done)
    );

    aq_axis_pack64 #(.CNT_W(16), .SWAP_HALF(1'b1)) dut_sw (
        .ACLK(clk), .ARESET(rst),
        .S_AXIS_TDATA(sw_s_tdata), .S_AXIS_TVALID(sw_s_tvalid), .S_AXIS_TREADY(sw_s_tready),
        .S_AXIS_TLAST(sw_s_tlast),
        .M_AXIS_TDATA(sw_m_tdata), .M_AXIS_TVALID(sw_m_tvalid), .M_AXIS_TREADY(1'b1),
        .M_AXIS_TSTRB(sw_m_tstrb), .M_AXIS_TKEEP(sw_m_tkeep), .M_AXIS_TLAST(sw_m_tlast),
        .FRAME_BEATS(sw_frame_beats), .FRAME_DONE(sw_frame_done)
    );

    typedef struct {
        logic [31:0] word;
        logic        last;
        logic        push;
        logic [63:0] edata;
        logic [7:0]  estrb;
        logic        elast;
    } vec_t;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  s;
        logic        l;
    } beat_t;

    vec_t  vecs [18];
    beat_t q [$];
    int    checks = 0;
    int    errors = 0;
    int    beats_seen = 0;
    int    done_cnt = 0;
    int    acc_cnt = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: compare every output handshake against the queue
    always @(negedge clk) begin
        if (!rst) begin
            if (m_tvalid && m_tready) begin
                beats_seen++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", m_tdata);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    chk("beat", {7'd0, m_tdata, m_tstrb, m_tlast}, {7'd0, e.d, e.s, e.l});
                end
            end
            if (frame_done) done_cnt++;
            if (s_tvalid && s_tready) acc_cnt++;
        end
    end

    task automatic send(input logic [31:0] w, input logic l);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        s_tdata  = w;
        s_tlast  = l;
        s_tvalid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (s_tready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                n++;
            end
        end
        s_tvalid = 1'b0;
        if (!ok) chk("send_timeout", 80'd0, 80'd1);
    endtask

    task automatic apply_vec(input int i);
        if (vecs[i].push) q.push_back({vecs[i].edata, vecs[i].estrb, vecs[i].elast});
        send(vecs[i].word, vecs[i].last);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 80'(q.size()), 80'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] held;
        int          snap;
        int          n;

        vecs[0]  = '{32'h1,  1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[1]  = '{32'h2,  1'b0, 1'b1, 64'h00000002_00000001, 8'hFF, 1'b0};
        vecs[2]  = '{32'h3,  1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[3]  = '{32'h4,  1'b1, 1'b1, 64'h00000004_00000003, 8'hFF, 1'b1};
        vecs[4]  = '{32'h5,  1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[5]  = '{32'h6,  1'b0, 1'b1, 64'h00000006_00000005, 8'hFF, 1'b0};
        vecs[6]  = '{32'h7,  1'b1, 1'b1, 64'h00000000_00000007, 8'h0F, 1'b1};
        vecs[7]  = '{32'hAA, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[8]  = '{32'h1,  1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[9]  = '{32'h2,  1'b1, 1'b1, 64'h00000002_00000001, 8'hFF, 1'b1};
        vecs[10] = '{32'h10, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[11] = '{32'h11, 1'b0, 1'b1, 64'h00000011_00000010, 8'hFF, 1'b0};
        vecs[12] = '{32'h12, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[13] = '{32'h13, 1'b0, 1'b1, 64'h00000013_00000012, 8'hFF, 1'b0};
        vecs[14] = '{32'h14, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[15] = '{32'h15, 1'b0, 1'b1, 64'h00000015_00000014, 8'hFF, 1'b0};
        vecs[16] = '{32'h16, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[17] = '{32'h17, 1'b1, 1'b1, 64'h00000017_00000016, 8'hFF, 1'b1};

        rst = 1'b1;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        sw_s_tdata = '0; sw_s_tvalid = 1'b0; sw_s_tlast = 1'b0;

        // Reset: two cycles, all outputs low, ready one cycle after release
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("rst_outputs", {6'd0, m_tvalid, m_tdata, m_tstrb, m_tlast, frame_done, s_tready}, 80'd0);
            chk("rst_frame_beats", 80'(frame_beats), 80'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 80'(s_tready), 80'd1);
        chk("tkeep", 80'(m_tkeep), 80'd1);

        // Even frame
        done_cnt = 0;
        for (int i = 0; i <= 3; i++) apply_vec(i);
        drain();
        chk("even_frame_beats", 80'(frame_beats), 80'd2);
        chk("even_frame_done", 80'(done_cnt), 80'd1);

        // Odd frame
        done_cnt = 0;
        for (int i = 4; i <= 6; i++) apply_vec(i);
        drain();
        chk("odd_frame_beats", 80'(frame_beats), 80'd2);
        chk("odd_frame_done", 80'(done_cnt), 80'd1);

        // Backpressure: FIFO fills after 4 words, output holds steady
        m_tready = 1'b0;
        acc_cnt  = 0;
        done_cnt = 0;
        for (int i = 10; i <= 13; i++) apply_vec(i);
        s_tdata = vecs[14].word; s_tlast = vecs[14].last; s_tvalid = 1'b1;
        @(negedge clk);
        held = m_tdata;
        repeat (4) @(negedge clk);
        chk("bp_ready_low", 80'(s_tready), 80'd0);
        chk("bp_valid_high", 80'(m_tvalid), 80'd1);
        chk("bp_data_steady", 80'(m_tdata), 80'(held));
        chk("bp_head_data", 80'(m_tdata), 80'h00000011_00000010);
        chk("bp_accepted", 80'(acc_cnt), 80'd4);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 14; i <= 17; i++) apply_vec(i);
        drain();
        chk("bp_frame_beats", 80'(frame_beats), 80'd4);
        chk("bp_frame_done", 80'(done_cnt), 80'd1);

        // Reset mid-frame: held word discarded, no beat emitted
        apply_vec(7);
        snap = beats_seen;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_beat", 80'(beats_seen), 80'(snap));
        chk("midrst_valid", 80'(m_tvalid), 80'd0);
        done_cnt = 0;
        for (int i = 8; i <= 9; i++) apply_vec(i);
        drain();
        chk("midrst_beats_total", 80'(beats_seen), 80'(snap + 1));
        chk("midrst_frame_beats", 80'(frame_beats), 80'd1);

        // SWAP_HALF=1 single-word frame
        sw_s_tdata = 32'h9; sw_s_tlast = 1'b1; sw_s_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!sw_s_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        sw_s_tvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!sw_m_tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("swap_beat", {7'd0, sw_m_tdata, sw_m_tstrb, sw_m_tlast}, {7'd0, 64'h00000009_00000000, 8'hF0, 1'b1});
        repeat (3) @(posedge clk);
        #1;
        chk("swap_frame_beats", 80'(sw_frame_beats), 80'd1);
        chk("swap_drained", 80'(sw_m_tvalid), 80'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/aq_axis_pack64.md
AQ_AXIS_PACK64 -- requirements
Module: aq_axis_pack64

Interface
REQ-001: Parameter CNT_W, default 16: width of the frame beat counter and of FRAME_BEATS.
REQ-002: Parameter SWAP_HALF, default 0: when 0, the first 32-bit word of a pair goes to output bits [31:0]; when 1, it goes to bits [63:32].
REQ-003: Clock and reset: one clock; reset is synchronous and active-high.
REQ-004: ACLK  in  1  block clock; all state changes on the rising edge.
REQ-005: ARESET  in  1  synchronous active-high reset.
REQ-006: S_AXIS_TDATA  in  32  upstream word.
REQ-007: S_AXIS_TVALID  in  1  upstream word valid.
REQ-008: S_AXIS_TREADY  out  1  block accepts a word.
REQ-009: S_AXIS_TLAST  in  1  last word of the frame.
REQ-010: M_AXIS_TDATA  out  64  packed beat to the DMA W_AXIS port.
REQ-011: M_AXIS_TVALID  out  1  packed beat valid.
REQ-012: M_AXIS_TREADY  in  1  downstream accepts the beat.
REQ-013: M_AXIS_TSTRB  out  8  byte strobes.
REQ-014: M_AXIS_TKEEP  out  1  constant 1.
REQ-015: M_AXIS_TLAST  out  1  last beat of the frame.
REQ-016: FRAME_BEATS  out  CNT_W  output beat count of the last completed frame.
REQ-017: FRAME_DONE  out  1  one-cycle pulse when a frame's final beat handshakes.

Function
REQ-018: A word is accepted only in a cycle where S_AXIS_TVALID and S_AXIS_TREADY are both 1; a beat is sent only in a cycle where M_AXIS_TVALID and M_AXIS_TREADY are both 1.
REQ-019: Pack state machine, state LOW (no word held): an accepted word without TLAST is stored in the hold register and the state moves to HIGH.
REQ-020: In state LOW, an accepted word with TLAST pushes a half beat and the state stays LOW: data is {32'h0, word} with TSTRB 8'h0F and TLAST 1 (mirrored to 8'hF0 and the upper half when SWAP_HALF=1).
REQ-021: Pack state machine, state HIGH (one word held): any accepted word pushes a full beat {word, hold} with TSTRB 8'hFF and TLAST equal to S_AXIS_TLAST, and the state moves to LOW.
REQ-022: Pushed beats enter a 2-entry output FIFO of {data, strb, last}; M_AXIS_* presents the FIFO head, registered.
REQ-023: S_AXIS_TREADY = (FIFO count != 2), driven from registers only; it has no combinational path from M_AXIS_TREADY.
REQ-024: Latency: a pushed beat is visible on M_AXIS_TVALID in the cycle after the accepting handshake if the FIFO was empty.
REQ-025: A push and a pop in the same cycle leave the FIFO count unchanged; beat order is strictly preserved.
REQ-026: With M_AXIS_TREADY held at 1, sustained throughput is 1 word per cycle on the input and 1 beat per 2 cycles on the output.
REQ-027: M_AXIS_TDATA, M_AXIS_TSTRB and M_AXIS_TLAST hold steady while M_AXIS_TVALID=1 and M_AXIS_TREADY=0.
REQ-028: The beat counter increments on each output handshake and saturates at all-ones.
REQ-029: On an output handshake with TLAST: FRAME_BEATS <= counter+1 (saturating), the counter clears to 0, and FRAME_DONE is 1 in the next cycle only.
REQ-030: A word with TLAST received in state HIGH closes the frame with a full beat; no extra half beat is emitted.

Reset
REQ-031: While ARESET=1 at a clock edge: state LOW, hold register and FIFO cleared, counter 0.
REQ-032: While ARESET=1 at a clock edge: M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TSTRB=0, M_AXIS_TLAST=0, FRAME_BEATS=0, FRAME_DONE=0, S_AXIS_TREADY=0.
REQ-033: S_AXIS_TREADY is 1 in the first cycle after ARESET deasserts.
REQ-034: Reset mid-frame discards the held word and all queued beats, emits no partial beat, and the next accepted word starts a new frame.

Verification
REQ-035: Reset: pulse ARESET for 2 cycles -> all outputs 0 during reset; S_AXIS_TREADY=1 one cycle after release.
REQ-036: Even frame: words 1,2,3,4 (TLAST on 4) with M_AXIS_TREADY=1 -> two beats:
  - 64'h00000002_00000001, TSTRB FF
  - 64'h00000004_00000003, TSTRB FF, TLAST 1
  - then FRAME_BEATS=2 and one FRAME_DONE pulse.
REQ-037: Odd frame: words 5,6,7 (TLAST on 7) -> two beats:
  - 64'h00000006_00000005, TSTRB FF
  - 64'h00000000_00000007, TSTRB 0F, TLAST 1
  - then FRAME_BEATS=2.
REQ-038: Backpressure: M_AXIS_TREADY=0 and 8 words offered -> exactly 4 words accepted, then S_AXIS_TREADY=0 and output steady. After M_AXIS_TREADY=1, all 4 beats arrive in order with no loss or duplication.
REQ-039: Reset mid-frame: accept word 8'hAA, then assert ARESET -> no beat emitted. Next frame 1,2(TLAST) -> single beat 64'h00000002_00000001.
REQ-040: SWAP_HALF=1 with single word 9 (TLAST) -> one beat 64'h00000009_00000000, TSTRB F0, TLAST 1, FRAME_BEATS=1.
